// File: rtl/single_port_ram_arbiter.sv
// Round-robin arbiter that shares one single-port RAM among several clients.
// Zero-fills the RAM after reset, then serves at most one read or write per cycle.
module single_port_ram_arbiter #(
  parameter int NUMBER_REQUESTER          = 4,
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
  parameter int NUMBER_SET                = 64,
  parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUMBER_SET),
  parameter int REQ_PTR_WIDTH_IN_BITS     = $clog2(NUMBER_REQUESTER)
) (
  input  logic                                                  clk_in,
  input  logic                                                  reset_n_in,
  input  logic [NUMBER_REQUESTER-1:0]                           request_valid_in,
  input  logic [NUMBER_REQUESTER-1:0]                           request_write_in,
  input  logic [NUMBER_REQUESTER*SET_PTR_WIDTH_IN_BITS-1:0]     request_addr_in,
  input  logic [NUMBER_REQUESTER*SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_data_in,
  output logic [NUMBER_REQUESTER-1:0]                           request_ready_out,
  output logic [NUMBER_REQUESTER-1:0]                           response_valid_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]                  response_data_out,
  output logic                                                  init_done_out,
  output logic                                                  ram_access_en_out,
  output logic                                                  ram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]                      ram_addr_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]                  ram_write_data_out,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]                  ram_read_data_in
);

  typedef enum logic {INIT, SERVE} state_t;

  localparam logic [NUMBER_REQUESTER-1:0] GRANT_BASE = {{(NUMBER_REQUESTER-1){1'b0}}, 1'b1};
  localparam logic [REQ_PTR_WIDTH_IN_BITS-1:0] LAST_REQ = REQ_PTR_WIDTH_IN_BITS'(NUMBER_REQUESTER-1);
  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUMBER_SET-1);

  state_t                              state;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]    counter;
  logic [REQ_PTR_WIDTH_IN_BITS-1:0]    rr_ptr;
  logic [REQ_PTR_WIDTH_IN_BITS-1:0]    grant_idx;
  logic [REQ_PTR_WIDTH_IN_BITS-1:0]    cand_idx;
  logic [REQ_PTR_WIDTH_IN_BITS-1:0]    next_ptr;
  int                                  cand_sum;
  logic                                grant_found;
  logic                                grant_valid;
  logic [NUMBER_REQUESTER-1:0]         grant_onehot;
  logic [NUMBER_REQUESTER-1:0]         resp_valid_q;

  logic [SET_PTR_WIDTH_IN_BITS-1:0]     addr_arr [NUMBER_REQUESTER];
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] data_arr [NUMBER_REQUESTER];

  for (genvar g = 0; g < NUMBER_REQUESTER; g++) begin : g_unpack
    assign addr_arr[g] = request_addr_in[g*SET_PTR_WIDTH_IN_BITS +: SET_PTR_WIDTH_IN_BITS];
    assign data_arr[g] = request_data_in[g*SINGLE_ENTRY_SIZE_IN_BITS +: SINGLE_ENTRY_SIZE_IN_BITS];
  end

  // Scan clients starting at rr_ptr; the wrap uses a compare so odd client counts work.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = 0;
    cand_idx    = '0;
    for (int off = 0; off < NUMBER_REQUESTER; off++) begin
      cand_sum = int'(rr_ptr) + off;
      if (cand_sum >= NUMBER_REQUESTER) begin
        cand_sum = cand_sum - NUMBER_REQUESTER;
      end
      cand_idx = REQ_PTR_WIDTH_IN_BITS'(cand_sum);
      if (!grant_found && request_valid_in[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign grant_valid  = grant_found && (state == SERVE) && reset_n_in;
  assign grant_onehot = grant_valid ? (GRANT_BASE << grant_idx) : '0;
  assign next_ptr     = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;

  assign request_ready_out  = grant_onehot;
  assign response_valid_out = reset_n_in ? resp_valid_q : '0;
  assign response_data_out  = reset_n_in ? ram_read_data_in : '0;
  assign init_done_out      = reset_n_in && (state == SERVE);

  always_comb begin
    ram_access_en_out  = 1'b0;
    ram_write_en_out   = 1'b0;
    ram_addr_out       = '0;
    ram_write_data_out = '0;
    if (reset_n_in && state == INIT) begin
      ram_access_en_out = 1'b1;
      ram_write_en_out  = 1'b1;
      ram_addr_out      = counter;
    end else if (grant_valid) begin
      ram_access_en_out  = 1'b1;
      ram_write_en_out   = request_write_in[grant_idx];
      ram_addr_out       = addr_arr[grant_idx];
      ram_write_data_out = data_arr[grant_idx];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state        <= INIT;
      counter      <= '0;
      rr_ptr       <= '0;
      resp_valid_q <= '0;
    end else begin
      case (state)
        INIT: begin
          resp_valid_q <= '0;
          if (counter == LAST_SET) begin
            state   <= SERVE;
            counter <= '0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        SERVE: begin
          resp_valid_q <= grant_onehot & ~request_write_in;
          if (grant_valid) begin
            rr_ptr <= next_ptr;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_single_port_ram_arbiter.sv
// Bench for single_port_ram_arbiter: directed requests with a queued scoreboard
// and an independent monitor that checks every read-return strobe.
module tb_single_port_ram_arbiter;

  localparam int N  = 4;
  localparam int D  = 64;
  localparam int S  = 64;
  localparam int AW = 6;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*D-1:0] req_data;
  logic [N-1:0]   ready;
  logic [N-1:0]   resp_valid;
  logic [D-1:0]   resp_data;
  logic           init_done;
  logic           ram_en;
  logic           ram_we;
  logic [AW-1:0]  ram_addr;
  logic [D-1:0]   ram_wdata;
  logic [D-1:0]   ram_rdata;

  logic [D-1:0]   mem [S];

  typedef struct {
    int           due;
    logic [N-1:0] onehot;
    logic [D-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests_run;
  int   tests_failed;
  int   cyc;

  single_port_ram_arbiter #(
    .NUMBER_REQUESTER(N),
    .SINGLE_ENTRY_SIZE_IN_BITS(D),
    .NUMBER_SET(S)
  ) dut (
    .clk_in(clk),
    .reset_n_in(reset_n),
    .request_valid_in(req_valid),
    .request_write_in(req_write),
    .request_addr_in(req_addr),
    .request_data_in(req_data),
    .request_ready_out(ready),
    .response_valid_out(resp_valid),
    .response_data_out(resp_data),
    .init_done_out(init_done),
    .ram_access_en_out(ram_en),
    .ram_write_en_out(ram_we),
    .ram_addr_out(ram_addr),
    .ram_write_data_out(ram_wdata),
    .ram_read_data_in(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External single-port RAM: registered read that holds until the next read.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // Monitor: every strobe must match the oldest expectation, in the cycle it is due.
  always @(negedge clk) begin
    #4;
    if (resp_valid !== '0) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_resp: got valid=%b data=%h, required no strobe", resp_valid, resp_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.due != cyc || mon_e.onehot !== resp_valid || mon_e.data !== resp_data) begin
          tests_failed++;
          $display("[TB] FAIL resp: got cyc=%0d valid=%b data=%h, required cyc=%0d valid=%b data=%h",
                   cyc, resp_valid, resp_data, mon_e.due, mon_e.onehot, mon_e.data);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL missing_resp: got no strobe at cyc=%0d, required valid=%b data=%h",
               cyc, mon_e.onehot, mon_e.data);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic setClient(input int c, input logic wr, input logic [AW-1:0] a, input logic [D-1:0] d);
    req_valid[c]          = 1'b1;
    req_write[c]          = wr;
    req_addr[c*AW +: AW]  = a;
    req_data[c*D +: D]    = d;
  endtask

  task automatic pushExpect(input int c, input logic [D-1:0] d);
    exp_t e;
    e.due    = cyc + 1;
    e.onehot = 4'b0001 << c;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  // One request from one client; waits (bounded) for its grant, then drops valid.
  task automatic applyStimulus(input string name, input int c, input logic wr, input logic [AW-1:0] a,
                               input logic [D-1:0] d, input logic [D-1:0] exp_rd, input bit push);
    logic [N-1:0] oh;
    oh = 4'b0001 << c;
    setClient(c, wr, a, d);
    #1;
    for (int k = 0; k < 8 && ready[c] !== 1'b1; k++) begin
      @(negedge clk);
      #2;
    end
    checkOutput({name, "_ready"}, 128'(ready), 128'(oh));
    checkOutput({name, "_ram"}, 128'({ram_en, ram_we, ram_addr, ram_wdata}), 128'({1'b1, wr, a, d}));
    if (!wr && push) pushExpect(c, exp_rd);
    @(negedge clk);
    #1;
    req_valid[c] = 1'b0;
  endtask

  // Called right as reset is released: checks every zero-fill cycle, then SERVE entry.
  task automatic initSweep();
    for (int i = 0; i < S; i++) begin
      #1;
      checkOutput("init_cycle",
                  128'({ram_en, ram_we, ram_addr, ram_wdata, ready, init_done}),
                  128'({1'b1, 1'b1, AW'(i), 64'h0, 4'h0, 1'b0}));
      @(negedge clk);
    end
    req_valid = '0;
    #1;
    checkOutput("init_done", 128'({ready, init_done, ram_en}), 128'({4'h0, 1'b1, 1'b0}));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    for (int i = 0; i < S; i++) mem[i] = 64'hBADC_0FFE_0000_0000 | 64'(i);
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    req_write = 4'b1111;
    req_addr  = '1;
    req_data  = '1;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_ctrl", 128'({ready, resp_valid, init_done, ram_en, ram_we, ram_addr}), 128'(0));
    checkOutput("reset_data", 128'({ram_wdata, resp_data}), 128'(0));
    reset_n = 1'b1;
    initSweep();

    applyStimulus("rd37", 0, 1'b0, 6'd37, 64'h0, 64'h0, 1'b1);

    applyStimulus("wr5", 2, 1'b1, 6'd5, 64'hDEAD_BEEF, 64'h0, 1'b0);
    applyStimulus("rd5", 2, 1'b0, 6'd5, 64'h0, 64'hDEAD_BEEF, 1'b1);
    applyStimulus("rd5_c3", 3, 1'b0, 6'd5, 64'h0, 64'hDEAD_BEEF, 1'b1);

    // Fairness: all four clients reading continuously from rr_ptr = 0.
    setClient(0, 1'b0, 6'd5, 64'h0);
    setClient(1, 1'b0, 6'd37, 64'h0);
    setClient(2, 1'b0, 6'd5, 64'h0);
    setClient(3, 1'b0, 6'd37, 64'h0);
    #1;
    for (int k = 0; k < 8; k++) begin
      checkOutput("fair_grant", 128'(ready), 128'(4'b0001 << (k % 4)));
      pushExpect(k % 4, ((k % 2) == 0) ? 64'hDEAD_BEEF : 64'h0);
      @(negedge clk);
      #2;
    end
    req_valid = '0;
    @(negedge clk);
    #1;

    // Wrap and skip: rr_ptr = 3 with only clients 1 and 3 valid.
    applyStimulus("rd37_c2", 2, 1'b0, 6'd37, 64'h0, 64'h0, 1'b1);
    setClient(1, 1'b0, 6'd5, 64'h0);
    setClient(3, 1'b0, 6'd37, 64'h0);
    #1;
    checkOutput("wrap_grant3", 128'(ready), 128'(4'b1000));
    pushExpect(3, 64'h0);
    @(negedge clk);
    #1;
    req_valid[3] = 1'b0;
    #1;
    checkOutput("skip_grant1", 128'(ready), 128'(4'b0010));
    pushExpect(1, 64'hDEAD_BEEF);
    @(negedge clk);
    #1;
    req_valid = '0;

    // Cross-client read-after-write on back-to-back cycles.
    applyStimulus("raw_wr", 0, 1'b1, 6'd9, 64'h1234, 64'h0, 1'b0);
    applyStimulus("raw_rd", 1, 1'b0, 6'd9, 64'h0, 64'h1234, 1'b1);

    // Reset one cycle after a read is accepted: its response must never appear.
    applyStimulus("pre_rst_wr", 0, 1'b1, 6'd20, 64'hAAAA_5555, 64'h0, 1'b0);
    setClient(0, 1'b0, 6'd20, 64'h0);
    #1;
    checkOutput("pre_rst_rd_ready", 128'(ready), 128'(4'b0001));
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = '0;
    #1;
    checkOutput("mid_rst_ctrl", 128'({ready, resp_valid, init_done, ram_en, ram_we, ram_addr}), 128'(0));
    checkOutput("mid_rst_data", 128'({ram_wdata, resp_data}), 128'(0));
    repeat (2) @(negedge clk);
    #1;
    checkOutput("mid_rst_hold", 128'({resp_valid, init_done, ram_en}), 128'(0));
    reset_n = 1'b1;
    initSweep();

    applyStimulus("post_rst_rd20", 0, 1'b0, 6'd20, 64'h0, 64'h0, 1'b1);
    applyStimulus("post_rst_rd9", 1, 1'b0, 6'd9, 64'h0, 64'h0, 1'b1);

    repeat (3) @(negedge clk);
    #6;
    checkOutput("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
